// File: rtl/run_timer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// run_timer_pkg : state encoding, BCD width and seven-segment ROM
// Rev 1.0
// ----------------------------------------------------------------------------
package run_timer_pkg;

  typedef enum logic [0:0] {
    RUNNING   = 1'b0,
    DEAD_HOLD = 1'b1
  } state_t;

  localparam int         c_bcd_w = 4;
  localparam logic [7:0] c_blank = 8'hFF;

  // Active-low {Ca..Cg,Dp}; entry n is the glyph for digit n with Dp dark.
  localparam logic [9:0][7:0] c_seg_rom = {
    8'h09, 8'h01, 8'h1F, 8'h41, 8'h49,
    8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    if (digit <= 4'd9) return c_seg_rom[digit];
    return c_blank;
  endfunction

endpackage
`default_nettype wire

// File: rtl/run_timer_scoreboard_ssd_scan_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ssd_scan_mux : multiplexed seven-segment scanner with registered An/cathodes
// Rev 1.0
// ----------------------------------------------------------------------------
module ssd_scan_mux
  import run_timer_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int SCAN_BITS = 17
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_DIGITS*c_bcd_w-1:0]   i_digits,
  input  logic [N_DIGITS-1:0]           i_dp_mask,
  input  logic [N_DIGITS-1:0]           i_blank_mask,
  output logic [N_DIGITS-1:0]           o_an,
  output logic [7:0]                    o_cath
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [SCAN_BITS-1:0] r_scan;
  logic [N_DIGITS-1:0]  r_an;
  logic [7:0]           r_cath;
  logic [IDX_W-1:0]     w_idx;
  logic [c_bcd_w-1:0]   w_digit;
  logic [N_DIGITS-1:0]  w_an;
  logic [7:0]           w_seg;

  assign w_idx = r_scan[SCAN_BITS-1 -: IDX_W];

  always_comb begin
    w_digit = i_digits[w_idx*c_bcd_w +: c_bcd_w];
    w_an    = '1;
    w_an[w_idx] = 1'b0;
    // A blanked digit keeps its anode so the scan duty cycle stays even.
    if (i_blank_mask[w_idx]) w_seg = c_blank;
    else                     w_seg = seg_decode(w_digit) & ~{7'd0, i_dp_mask[w_idx]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scan <= '0;
      r_an   <= '1;
      r_cath <= c_blank;
    end else begin
      r_scan <= r_scan + 1'b1;
      r_an   <= w_an;
      r_cath <= w_seg;
    end
  end

  assign o_an   = r_an;
  assign o_cath = r_cath;

endmodule
`default_nettype wire

// File: rtl/run_timer_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// run_timer_scoreboard : BCD run timer with best-time record and 8-digit SSD
// Rev 1.0
// ----------------------------------------------------------------------------
module run_timer_scoreboard
  import run_timer_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int TICK_HZ    = 100,
  parameter int CUR_DIGITS = 4,
  parameter int HOLD_TICKS = 200,
  parameter int SCAN_BITS  = 17,
  parameter int BLINK_BIT  = 5
) (
  input  logic                          ClkPort,
  input  logic                          Reset,
  input  logic                          dead_in,
  input  logic                          pause,
  output logic [2*CUR_DIGITS-1:0]       An,
  output logic [7:0]                    SSD_CATHODES,
  output logic [c_bcd_w*CUR_DIGITS-1:0] cur_time,
  output logic [c_bcd_w*CUR_DIGITS-1:0] best_time,
  output logic                          new_record
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int HOLD_W   = ($clog2(HOLD_TICKS) > BLINK_BIT) ? $clog2(HOLD_TICKS) : BLINK_BIT + 1;
  localparam int TIME_W   = c_bcd_w * CUR_DIGITS;
  localparam logic [2*CUR_DIGITS-1:0] c_dp_mask =
    (2*CUR_DIGITS)'((1 << 2) | (1 << (CUR_DIGITS + 2)));

  logic              r_dead_s1, r_dead_s2, r_dead_s3;
  logic [PRE_W-1:0]  r_presc;
  state_t            r_state;
  logic [TIME_W-1:0] r_cur, r_best;
  logic [HOLD_W-1:0] r_hold;
  logic              r_rec_flag, r_new_record;

  logic              w_dead_pulse, w_frozen, w_tick, w_all9, w_carry, w_blink_off;
  logic [TIME_W-1:0] w_cur_inc;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_dead_s1 <= 1'b0;
      r_dead_s2 <= 1'b0;
      r_dead_s3 <= 1'b0;
    end else begin
      r_dead_s1 <= dead_in;
      r_dead_s2 <= r_dead_s1;
      r_dead_s3 <= r_dead_s2;
    end
  end

  assign w_dead_pulse = r_dead_s2 & ~r_dead_s3;
  assign w_frozen     = (r_state == RUNNING) && pause;
  assign w_tick       = (r_presc == PRE_W'(PRESCALE - 1)) && !w_frozen;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset)          r_presc <= '0;
    else if (w_tick)    r_presc <= '0;
    else if (!w_frozen) r_presc <= r_presc + 1'b1;
  end

  // Ripple BCD increment; all-9s is detected separately so the count saturates.
  always_comb begin
    w_carry   = 1'b1;
    w_all9    = 1'b1;
    w_cur_inc = r_cur;
    for (int i = 0; i < CUR_DIGITS; i++) begin
      if (r_cur[i*c_bcd_w +: c_bcd_w] != 4'd9) w_all9 = 1'b0;
      if (w_carry) begin
        if (r_cur[i*c_bcd_w +: c_bcd_w] == 4'd9) begin
          w_cur_inc[i*c_bcd_w +: c_bcd_w] = '0;
        end else begin
          w_cur_inc[i*c_bcd_w +: c_bcd_w] = r_cur[i*c_bcd_w +: c_bcd_w] + 4'd1;
          w_carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_state      <= RUNNING;
      r_cur        <= '0;
      r_best       <= '0;
      r_hold       <= '0;
      r_rec_flag   <= 1'b0;
      r_new_record <= 1'b0;
    end else begin
      r_new_record <= 1'b0;
      case (r_state)
        RUNNING: begin
          // Death outranks a coincident tick so the compare sees the pre-tick time.
          if (w_dead_pulse) begin
            r_state <= DEAD_HOLD;
            r_hold  <= '0;
            if (r_cur > r_best) begin
              r_best       <= r_cur;
              r_new_record <= 1'b1;
              r_rec_flag   <= 1'b1;
            end else begin
              r_rec_flag   <= 1'b0;
            end
          end else if (w_tick && !w_all9) begin
            r_cur <= w_cur_inc;
          end
        end
        DEAD_HOLD: begin
          if (w_tick) begin
            if (r_hold == HOLD_W'(HOLD_TICKS - 1)) begin
              r_cur   <= '0;
              r_hold  <= '0;
              r_state <= RUNNING;
            end else begin
              r_hold  <= r_hold + 1'b1;
            end
          end
        end
        default: r_state <= RUNNING;
      endcase
    end
  end

  assign w_blink_off = (r_state == DEAD_HOLD) && r_rec_flag && r_hold[BLINK_BIT];

  ssd_scan_mux #(
    .N_DIGITS  (2*CUR_DIGITS),
    .SCAN_BITS (SCAN_BITS)
  ) u_scan (
    .i_clk        (ClkPort),
    .i_rst        (Reset),
    .i_digits     ({r_best, r_cur}),
    .i_dp_mask    (c_dp_mask),
    .i_blank_mask ({{CUR_DIGITS{w_blink_off}}, {CUR_DIGITS{1'b0}}}),
    .o_an         (An),
    .o_cath       (SSD_CATHODES)
  );

  assign cur_time   = r_cur;
  assign best_time  = r_best;
  assign new_record = r_new_record;

endmodule
`default_nettype wire

// File: tb/tb_run_timer_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_run_timer_scoreboard : scenario bench for run_timer_scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_run_timer_scoreboard;

  logic        ClkPort = 1'b0;
  logic        Reset   = 1'b1;
  logic        dead_in = 1'b0;
  logic        pause   = 1'b0;
  logic [7:0]  an, cath, an_f, cath_f;
  logic [15:0] cur, best, cur_f, best_f;
  logic        nrec, nrec_f;

  int n_checks   = 0;
  int n_fail     = 0;
  int rec_pulses = 0;
  int cyc        = 0;

  logic [15:0] exp_best_q[$];
  // Expected cathodes per scan index for cur=0042, best=0150.
  logic [7:0]  seg_exp [8] = '{8'h25, 8'h99, 8'h02, 8'h03, 8'h03, 8'h49, 8'h9E, 8'h03};

  always #5 ClkPort = ~ClkPort;

  run_timer_scoreboard #(
    .CLK_HZ(1000), .TICK_HZ(100), .CUR_DIGITS(4), .HOLD_TICKS(5), .SCAN_BITS(6), .BLINK_BIT(1)
  ) dut (
    .ClkPort(ClkPort), .Reset(Reset), .dead_in(dead_in), .pause(pause),
    .An(an), .SSD_CATHODES(cath), .cur_time(cur), .best_time(best), .new_record(nrec)
  );

  // One tick per clock, used to reach the saturation region quickly.
  run_timer_scoreboard #(
    .CLK_HZ(1000), .TICK_HZ(1000), .CUR_DIGITS(4), .HOLD_TICKS(5), .SCAN_BITS(6), .BLINK_BIT(1)
  ) dut_f (
    .ClkPort(ClkPort), .Reset(Reset), .dead_in(dead_in), .pause(pause),
    .An(an_f), .SSD_CATHODES(cath_f), .cur_time(cur_f), .best_time(best_f), .new_record(nrec_f)
  );

  always @(posedge ClkPort or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge ClkPort) begin
    if (!Reset && nrec) rec_pulses <= rec_pulses + 1;
  end

  task automatic do_reset();
    Reset = 1'b1; dead_in = 1'b0; pause = 1'b0;
    repeat (2) @(negedge ClkPort);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; dead_in = 1'b0; pause = 1'b0;
    @(negedge ClkPort);
    n_checks++; if (cur !== 16'h0000) begin n_fail++; $display("FAIL reset_cur: got %h expected 0000", cur); end
    n_checks++; if (best !== 16'h0000) begin n_fail++; $display("FAIL reset_best: got %h expected 0000", best); end
    n_checks++; if (nrec !== 1'b0) begin n_fail++; $display("FAIL reset_new_record: got %b expected 0", nrec); end
    n_checks++; if (an !== 8'hFF || an_f !== 8'hFF) begin n_fail++; $display("FAIL reset_an: got %h/%h expected FF", an, an_f); end
    n_checks++; if (cath !== 8'hFF || cath_f !== 8'hFF) begin n_fail++; $display("FAIL reset_cath: got %h/%h expected FF", cath, cath_f); end
    @(negedge ClkPort);
    Reset = 1'b0;
    @(negedge ClkPort);
    n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL first_scan_an: got %h expected FE", an); end
    n_checks++; if (cath !== 8'h03) begin n_fail++; $display("FAIL first_scan_cath: got %h expected 03", cath); end
  endtask

  task automatic test_run_count();
    int p0;
    do_reset();
    p0 = rec_pulses;
    repeat (12339) @(negedge ClkPort);
    n_checks++; if (cur !== 16'h1233) begin n_fail++; $display("FAIL run_1233: got %h expected 1233", cur); end
    @(negedge ClkPort);
    n_checks++; if (cur !== 16'h1234) begin n_fail++; $display("FAIL run_1234: got %h expected 1234", cur); end
    n_checks++; if (best !== 16'h0000) begin n_fail++; $display("FAIL run_best: got %h expected 0000", best); end
    n_checks++; if (rec_pulses !== p0) begin n_fail++; $display("FAIL run_no_record: pulses %0d expected %0d", rec_pulses, p0); end
  endtask

  task automatic test_record();
    int p0, p1;
    logic [15:0] exp_v;
    do_reset();
    p0 = rec_pulses;
    repeat (1500) @(negedge ClkPort);
    n_checks++; if (cur !== 16'h0150) begin n_fail++; $display("FAIL rec_pre_cur: got %h expected 0150", cur); end
    dead_in = 1'b1;
    exp_best_q.push_back(16'h0150);
    repeat (2) @(negedge ClkPort);
    n_checks++; if (nrec !== 1'b0) begin n_fail++; $display("FAIL rec_early: got %b expected 0", nrec); end
    @(negedge ClkPort);
    n_checks++; if (nrec !== 1'b1) begin n_fail++; $display("FAIL rec_pulse: got %b expected 1", nrec); end
    if (exp_best_q.size() > 0) begin
      exp_v = exp_best_q.pop_front();
      n_checks++; if (best !== exp_v) begin n_fail++; $display("FAIL rec_best: got %h expected %h", best, exp_v); end
    end else begin
      n_checks++; n_fail++; $display("FAIL rec_queue: got empty expected an entry");
    end
    @(negedge ClkPort);
    n_checks++; if (nrec !== 1'b0) begin n_fail++; $display("FAIL rec_one_cycle: got %b expected 0", nrec); end
    dead_in = 1'b0;
    repeat (45) @(negedge ClkPort);
    n_checks++; if (cur !== 16'h0150) begin n_fail++; $display("FAIL hold_frozen: got %h expected 0150", cur); end
    @(negedge ClkPort);
    n_checks++; if (cur !== 16'h0000) begin n_fail++; $display("FAIL hold_exit: got %h expected 0000", cur); end
    repeat (1000) @(negedge ClkPort);
    n_checks++; if (cur !== 16'h0100) begin n_fail++; $display("FAIL rerun_cur: got %h expected 0100", cur); end
    p1 = rec_pulses;
    dead_in = 1'b1;
    repeat (10) @(negedge ClkPort);
    dead_in = 1'b0;
    n_checks++; if (best !== 16'h0150) begin n_fail++; $display("FAIL lower_best: got %h expected 0150", best); end
    n_checks++; if (cur !== 16'h0100) begin n_fail++; $display("FAIL lower_hold_cur: got %h expected 0100", cur); end
    n_checks++; if (rec_pulses !== p1 || p1 !== p0 + 1) begin n_fail++; $display("FAIL lower_no_pulse: pulses %0d expected %0d", rec_pulses, p0 + 1); end
  endtask

  task automatic test_held_dead();
    int p0;
    logic [15:0] exp_v;
    do_reset();
    p0 = rec_pulses;
    repeat (200) @(negedge ClkPort);
    dead_in = 1'b1;
    exp_best_q.push_back(16'h0020);
    repeat (3) @(negedge ClkPort);
    n_checks++; if (nrec !== 1'b1) begin n_fail++; $display("FAIL held_pulse: got %b expected 1", nrec); end
    if (exp_best_q.size() > 0) begin
      exp_v = exp_best_q.pop_front();
      n_checks++; if (best !== exp_v) begin n_fail++; $display("FAIL held_best: got %h expected %h", best, exp_v); end
    end else begin
      n_checks++; n_fail++; $display("FAIL held_queue: got empty expected an entry");
    end
    repeat (7) @(negedge ClkPort);
    dead_in = 1'b0; repeat (2) @(negedge ClkPort);
    dead_in = 1'b1; repeat (3) @(negedge ClkPort);
    dead_in = 1'b0; @(negedge ClkPort);
    dead_in = 1'b1;
    repeat (484) @(negedge ClkPort);
    n_checks++; if (rec_pulses !== p0 + 1) begin n_fail++; $display("FAIL held_once: pulses %0d expected %0d", rec_pulses, p0 + 1); end
    n_checks++; if (best !== 16'h0020) begin n_fail++; $display("FAIL held_best_end: got %h expected 0020", best); end
    n_checks++; if (cur !== 16'h0045) begin n_fail++; $display("FAIL held_single_entry: cur %h expected 0045", cur); end
    dead_in = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (9998) @(negedge ClkPort);
    n_checks++; if (cur_f !== 16'h9998) begin n_fail++; $display("FAIL sat_9998: got %h expected 9998", cur_f); end
    repeat (3) @(negedge ClkPort);
    n_checks++; if (cur_f !== 16'h9999) begin n_fail++; $display("FAIL sat_9999: got %h expected 9999", cur_f); end
    repeat (20) @(negedge ClkPort);
    n_checks++; if (cur_f !== 16'h9999) begin n_fail++; $display("FAIL sat_hold: got %h expected 9999", cur_f); end
    do_reset();
    repeat (100) @(negedge ClkPort);
    n_checks++; if (cur_f !== 16'h0100) begin n_fail++; $display("FAIL coinc_pre: got %h expected 0100", cur_f); end
    dead_in = 1'b1;
    repeat (3) @(negedge ClkPort);
    n_checks++; if (nrec_f !== 1'b1) begin n_fail++; $display("FAIL coinc_pulse: got %b expected 1", nrec_f); end
    n_checks++; if (best_f !== 16'h0102) begin n_fail++; $display("FAIL coinc_best: got %h expected 0102", best_f); end
    n_checks++; if (cur_f !== 16'h0102) begin n_fail++; $display("FAIL coinc_cur: got %h expected 0102", cur_f); end
    dead_in = 1'b0;
  endtask

  task automatic test_pause_and_reset();
    do_reset();
    repeat (74) @(negedge ClkPort);
    n_checks++; if (cur !== 16'h0007) begin n_fail++; $display("FAIL pause_pre: got %h expected 0007", cur); end
    pause = 1'b1;
    repeat (40) @(negedge ClkPort);
    n_checks++; if (cur !== 16'h0007) begin n_fail++; $display("FAIL pause_hold: got %h expected 0007", cur); end
    pause = 1'b0;
    repeat (5) @(negedge ClkPort);
    n_checks++; if (cur !== 16'h0007) begin n_fail++; $display("FAIL pause_phase_early: got %h expected 0007", cur); end
    @(negedge ClkPort);
    n_checks++; if (cur !== 16'h0008) begin n_fail++; $display("FAIL pause_phase: got %h expected 0008", cur); end
    dead_in = 1'b1;
    repeat (10) @(negedge ClkPort);
    n_checks++; if (best !== 16'h0008) begin n_fail++; $display("FAIL midhold_best: got %h expected 0008", best); end
    Reset = 1'b1;
    #1;
    n_checks++; if (cur !== 16'h0000 || best !== 16'h0000) begin n_fail++; $display("FAIL async_reset_times: got %h/%h expected 0000/0000", cur, best); end
    n_checks++; if (nrec !== 1'b0) begin n_fail++; $display("FAIL async_reset_rec: got %b expected 0", nrec); end
    n_checks++; if (an !== 8'hFF || cath !== 8'hFF) begin n_fail++; $display("FAIL async_reset_ssd: got %h/%h expected FF/FF", an, cath); end
    dead_in = 1'b0;
    @(negedge ClkPort);
    Reset = 1'b0;
  endtask

  task automatic test_scan();
    int k;
    logic [2:0] idx;
    logic [7:0] exp_an;
    do_reset();
    repeat (1500) @(negedge ClkPort);
    dead_in = 1'b1;
    for (int i = 0; i < 470; i++) begin
      @(negedge ClkPort);
      if (i == 5) dead_in = 1'b0;
      k = cyc;
      idx = 3'(((k - 1) % 64) / 8);
      exp_an = ~(8'b1 << idx);
      if (k >= 1521 && k <= 1540 && idx >= 3'd4) begin
        n_checks++; if (cath !== 8'hFF || an !== exp_an) begin n_fail++; $display("FAIL blink_blank: cyc %0d an/cath %h/%h expected %h/FF", k, an, cath, exp_an); end
      end else if (k >= 1505 && k <= 1519 && idx >= 3'd4) begin
        n_checks++; if (cath !== ((idx == 3'd4) ? 8'h03 : 8'h49)) begin n_fail++; $display("FAIL blink_visible: cyc %0d cath %h idx %0d", k, cath, idx); end
      end
    end
    n_checks++; if (cur !== 16'h0042 || best !== 16'h0150) begin n_fail++; $display("FAIL scan_setup: got %h/%h expected 0042/0150", cur, best); end
    pause = 1'b1;
    repeat (80) begin
      @(negedge ClkPort);
      k = cyc;
      idx = 3'(((k - 1) % 64) / 8);
      exp_an = ~(8'b1 << idx);
      n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL scan_an: cyc %0d got %h expected %h", k, an, exp_an); end
      n_checks++; if (cath !== seg_exp[idx]) begin n_fail++; $display("FAIL scan_cath: idx %0d got %h expected %h", idx, cath, seg_exp[idx]); end
    end
    n_checks++; if (cur !== 16'h0042) begin n_fail++; $display("FAIL scan_paused_cur: got %h expected 0042", cur); end
    pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_record();
    test_held_dead();
    test_saturate();
    test_pause_and_reset();
    test_scan();
    n_checks++; if (exp_best_q.size() != 0) begin n_fail++; $display("FAIL queue_drain: %0d left expected 0", exp_best_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
